ctrl_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute control unit for the lab CPU; sits directly upstream of the ALU.

---
 rtl/ctrl_sequencer_pkg.sv | 34 +++
 rtl/ctrl_sequencer_pc_reg.sv | 37 +++
 rtl/ctrl_sequencer.sv | 105 ++++++++++
 tb/tb_ctrl_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the lab CPU control path: opcode values (identical to the
// ALU operation codes), sequencer state encoding and the ALU operation width.
package ctrl_sequencer_pkg;

    localparam int ALU_OP_W = 7;

    localparam logic [3:0] OP_CLA = 4'h0;
    localparam logic [3:0] OP_COM = 4'h1;
    localparam logic [3:0] OP_SHR = 4'h2;
    localparam logic [3:0] OP_CSL = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_STA = 4'h6;
    localparam logic [3:0] OP_LDA = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_BAN = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPRD,
        S_EXEC,
        S_WB,
        S_MEMWR,
        S_HALT
    } state_e;

    // Opcode 4 and A..E have no ALU meaning; the sequencer skips them like a NOP.
    function automatic logic op_is_legal(input logic [3:0] op);
        return !((op == 4'h4) || ((op >= 4'hA) && (op <= 4'hE)));
    endfunction

endpackage

// File: rtl/ctrl_sequencer_pc_reg.sv
// Program counter: reset to PC_RST, parallel load has priority over increment,
// increment wraps modulo 2^ADDR_W.
module ctrl_sequencer_pc_reg #(
    parameter int                 ADDR_W = 4,
    parameter logic [ADDR_W-1:0]  PC_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RST;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute sequencer for the lab CPU; owns PC and IR and drives the ALU opcode.
// Memory handshakes stall in place until mem_ready; start is only honoured from IDLE/HALT.
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int                 ADDR_W = 4,
    parameter int                 OPC_W  = 4,
    parameter logic [ADDR_W-1:0]  PC_RST = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [OPC_W+ADDR_W-1:0] mem_rdata,
    input  logic                    mem_ready,
    input  logic                    acc_msb,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    m_sel,
    output logic [ALU_OP_W-1:0]     alu_op,
    output logic                    acc_we,
    output logic [ADDR_W-1:0]       pc,
    output logic                    halted,
    output logic                    busy
);

    state_e                  state_q;
    logic [OPC_W+ADDR_W-1:0] ir_q;
    logic [OPC_W-1:0]        opc;
    logic [ADDR_W-1:0]       ir_addr;
    logic                    pc_inc;
    logic                    pc_load;

    assign opc     = ir_q[OPC_W+ADDR_W-1:ADDR_W];
    assign ir_addr = ir_q[ADDR_W-1:0];

    // PC already points past the instruction while in DECODE, so a taken branch overrides it.
    assign pc_inc  = (state_q == S_FETCH) && mem_ready;
    assign pc_load = (state_q == S_DECODE) &&
                     ((opc == OPC_W'(OP_JMP)) || ((opc == OPC_W'(OP_BAN)) && acc_msb));

    ctrl_sequencer_pc_reg #(
        .ADDR_W (ADDR_W),
        .PC_RST (PC_RST)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (pc_inc),
        .load_i     (pc_load),
        .load_val_i (ir_addr),
        .pc_o       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if ((opc == OPC_W'(OP_ADD)) || (opc == OPC_W'(OP_LDA))) begin
                        state_q <= S_OPRD;
                    end else if ((opc == OPC_W'(OP_JMP)) || (opc == OPC_W'(OP_BAN))) begin
                        state_q <= S_FETCH;
                    end else if (opc == OPC_W'(OP_HLT)) begin
                        state_q <= S_HALT;
                    end else if (!op_is_legal(4'(opc))) begin
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_OPRD: begin
                    if (mem_ready) state_q <= S_EXEC;
                end
                S_EXEC: state_q <= S_WB;
                // STA spends WB without a write strobe, then performs the memory write.
                S_WB: state_q <= (opc == OPC_W'(OP_STA)) ? S_MEMWR : S_FETCH;
                S_MEMWR: begin
                    if (mem_ready) state_q <= S_FETCH;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_rd   = (state_q == S_FETCH) || (state_q == S_OPRD);
    assign mem_wr   = (state_q == S_MEMWR);
    assign mem_addr = (state_q == S_FETCH) ? pc : ir_addr;
    assign m_sel    = (state_q == S_OPRD);
    assign alu_op   = (state_q == S_EXEC) ? ALU_OP_W'(opc) : '0;
    assign acc_we   = (state_q == S_WB) && (opc != OPC_W'(OP_STA));
    assign halted   = (state_q == S_HALT);
    assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: an instruction-level model expands each program into a
// per-cycle expectation/stimulus trace that is replayed and compared every cycle.
module tb_ctrl_sequencer;

    typedef struct packed {
        logic       rd, wr, msel, we, busy, hlt, achk;
        logic [3:0] addr, pc;
        logic [6:0] alu;
    } exp_t;

    typedef struct packed {
        logic st, rdy, msb;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n, start, mem_ready, acc_msb;
    logic [7:0] mem_rdata;
    logic       mem_rd, mem_wr, m_sel, acc_we, halted, busy;
    logic [3:0] mem_addr, pc;
    logic [6:0] alu_op;

    logic [7:0] mem [16];
    exp_t       exp_q[$];
    stim_t      stim_q[$];
    logic [3:0] m_pc;
    int         fixed_w;
    bit         fixed_msb;
    bit         running = 1'b0;
    int         cyc;
    int         checks = 0;
    int         failures = 0;

    logic       obs_rd[4096], obs_wr[4096], obs_msel[4096], obs_we[4096], obs_hlt[4096];
    logic [3:0] obs_addr[4096], obs_pc[4096];
    logic [6:0] obs_alu[4096];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    ctrl_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .acc_msb   (acc_msb),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .m_sel     (m_sel),
        .alu_op    (alu_op),
        .acc_we    (acc_we),
        .pc        (pc),
        .halted    (halted),
        .busy      (busy)
    );

    task automatic chk8(input string nm, input int k, input logic [7:0] act, input logic [7:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, k, act, ex);
        end
    endtask

    task automatic chk1(input string nm, input int k, input logic act, input logic ex);
        chk8(nm, k, {7'b0, act}, {7'b0, ex});
    endtask

    // ---------------- model ----------------
    function automatic exp_t busy_rec();
        exp_t e;
        e = '0;
        e.busy = 1'b1;
        e.pc = m_pc;
        return e;
    endfunction

    function automatic stim_t noise(input bit rnd);
        stim_t s;
        s = '0;
        if (rnd) begin
            s.st  = ($urandom_range(0, 1) != 0);
            s.rdy = ($urandom_range(0, 1) != 0);
            s.msb = ($urandom_range(0, 1) != 0);
        end
        return s;
    endfunction

    function automatic int wgen();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    task automatic emit(input exp_t e, input stim_t s);
        exp_q.push_back(e);
        stim_q.push_back(s);
    endtask

    // One memory handshake: request held for w wait cycles plus the ready cycle.
    task automatic hs(input bit rnd, input int fw, input bit rd, input bit wr, input bit msel,
                      input logic [3:0] a);
        exp_t  e;
        stim_t s;
        int    w;
        w = rnd ? wgen() : fw;
        for (int i = 0; i <= w; i++) begin
            e = busy_rec();
            e.rd = rd; e.wr = wr; e.msel = msel; e.achk = 1'b1; e.addr = a;
            s = noise(rnd);
            s.rdy = (i == w);
            emit(e, s);
        end
    endtask

    task automatic exec_wb(input bit rnd, input logic [3:0] op, input bit we);
        exp_t e;
        e = busy_rec();
        e.alu = {3'b0, op};
        emit(e, noise(rnd));
        e = busy_rec();
        e.we = we;
        emit(e, noise(rnd));
    endtask

    task automatic gen(input bit rnd, input int max_cyc);
        exp_t       e;
        stim_t      s;
        logic [7:0] ir;
        logic [3:0] op, ia;
        bit         a, done;
        int         k;
        exp_q.delete();
        stim_q.delete();
        m_pc = 4'd0;
        done = 1'b0;
        e = '0; e.pc = m_pc;
        s = noise(rnd); s.st = 1'b1;
        emit(e, s);
        while (!done && exp_q.size() < max_cyc) begin
            hs(rnd, 0, 1'b1, 1'b0, 1'b0, m_pc);
            ir = mem[m_pc];
            op = ir[7:4];
            ia = ir[3:0];
            m_pc = m_pc + 4'd1;
            a = rnd ? ($urandom_range(0, 1) != 0) : fixed_msb;
            e = busy_rec();
            s = noise(rnd); s.msb = a;
            emit(e, s);
            case (op)
                4'h5, 4'h7: begin
                    hs(rnd, fixed_w, 1'b1, 1'b0, 1'b1, ia);
                    exec_wb(rnd, op, 1'b1);
                end
                4'h6: begin
                    exec_wb(rnd, op, 1'b0);
                    hs(rnd, 0, 1'b0, 1'b1, 1'b0, ia);
                end
                4'h0, 4'h1, 4'h2, 4'h3: exec_wb(rnd, op, 1'b1);
                4'h8: m_pc = ia;
                4'h9: if (a) m_pc = ia;
                4'hF: begin
                    k = (!rnd || exp_q.size() >= max_cyc) ? 1 : int'($urandom_range(1, 3));
                    for (int i = 0; i < k; i++) begin
                        e = '0; e.hlt = 1'b1; e.pc = m_pc;
                        s = noise(rnd);
                        s.st = rnd && (exp_q.size() < max_cyc) && (i == k - 1);
                        emit(e, s);
                    end
                    if (!s.st) done = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- replay and compare ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        running = 1'b0;
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; acc_msb = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_trace();
        do_reset();
        for (int k = 0; k < exp_q.size(); k++) begin
            cyc = k;
            start = stim_q[k].st;
            mem_ready = stim_q[k].rdy;
            acc_msb = stim_q[k].msb;
            running = 1'b1;
            step();
        end
        running = 1'b0;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (running) begin
            e = exp_q[cyc];
            obs_rd[cyc] = mem_rd;   obs_wr[cyc] = mem_wr;   obs_msel[cyc] = m_sel;
            obs_we[cyc] = acc_we;   obs_hlt[cyc] = halted;  obs_addr[cyc] = mem_addr;
            obs_pc[cyc] = pc;       obs_alu[cyc] = alu_op;
            chk1("mem_rd", cyc, mem_rd, e.rd);
            chk1("mem_wr", cyc, mem_wr, e.wr);
            chk1("m_sel", cyc, m_sel, e.msel);
            chk1("acc_we", cyc, acc_we, e.we);
            chk1("busy", cyc, busy, e.busy);
            chk1("halted", cyc, halted, e.hlt);
            chk8("alu_op", cyc, {1'b0, alu_op}, {1'b0, e.alu});
            chk8("pc", cyc, {4'b0, pc}, {4'b0, e.pc});
            if (e.achk) chk8("mem_addr", cyc, {4'b0, mem_addr}, {4'b0, e.addr});
            chk1("rd_wr_excl", cyc, mem_rd & mem_wr, 1'b0);
        end
    end

    function automatic int count_we();
        int n = 0;
        for (int k = 0; k < exp_q.size(); k++) n += int'(obs_we[k]);
        return n;
    endfunction

    function automatic int count_msel();
        int n = 0;
        for (int k = 0; k < exp_q.size(); k++) n += int'(obs_msel[k]);
        return n;
    endfunction

    task automatic fill_hlt();
        for (int i = 0; i < 16; i++) mem[i] = 8'hF0;
        fixed_w = 0;
        fixed_msb = 1'b0;
    endtask

    initial begin
        fill_hlt();
        // Reset state, then a reset in the middle of a stalled fetch.
        do_reset();
        chk8("rst_pc", 0, {4'b0, pc}, 8'h00);
        chk1("rst_busy", 0, busy, 1'b0);
        chk1("rst_halted", 0, halted, 1'b0);
        chk1("rst_mem_rd", 0, mem_rd, 1'b0);
        chk8("rst_alu_op", 0, {1'b0, alu_op}, 8'h00);
        chk1("rst_acc_we", 0, acc_we, 1'b0);
        mem[0] = 8'h00;
        start = 1'b1; step();
        start = 1'b0; mem_ready = 1'b1; step();
        mem_ready = 1'b0;
        repeat (3) step();
        chk8("mf_fetch_pc", 0, {3'b0, mem_rd, pc}, 8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("mf_rd_drop", 0, mem_rd, 1'b0);
        chk8("mf_pc", 0, {4'b0, pc}, 8'h00);
        chk1("mf_busy", 0, busy, 1'b0);
        step();
        rst_n = 1'b1; start = 1'b1; step();
        start = 1'b0;
        chk1("mf_restart_rd", 0, mem_rd, 1'b1);
        chk8("mf_restart_addr", 0, {4'b0, mem_addr}, 8'h00);

        // CLA; COM; HLT
        fill_hlt();
        mem[0] = 8'h00; mem[1] = 8'h10; mem[2] = 8'hF0;
        gen(1'b0, 100);
        run_trace();
        chk1("cla_we4", 4, obs_we[4], 1'b1);
        chk1("com_we8", 8, obs_we[8], 1'b1);
        chk8("prog1_we_count", 0, 8'(count_we()), 8'd2);
        chk8("com_alu7", 7, {1'b0, obs_alu[7]}, 8'h01);
        chk1("prog1_halted", 11, obs_hlt[11], 1'b1);
        chk8("prog1_pc", 11, {4'b0, obs_pc[11]}, 8'h03);

        // LDA 5 with three wait cycles on the operand read
        fill_hlt();
        mem[0] = 8'h75; fixed_w = 3;
        gen(1'b0, 100);
        run_trace();
        chk8("lda_msel_count", 0, 8'(count_msel()), 8'd4);
        chk8("lda_addr", 3, {4'b0, obs_addr[3]}, 8'h05);
        chk1("lda_we8", 8, obs_we[8], 1'b1);

        // BAN 9, taken and not taken
        fill_hlt();
        mem[0] = 8'h99; fixed_msb = 1'b1;
        gen(1'b0, 100);
        run_trace();
        chk8("ban_taken_fetch", 3, {3'b0, obs_rd[3], obs_addr[3]}, 8'h19);
        chk8("ban_taken_we", 0, 8'(count_we()), 8'd0);
        fixed_msb = 1'b0;
        gen(1'b0, 100);
        run_trace();
        chk8("ban_fall_fetch", 3, {3'b0, obs_rd[3], obs_addr[3]}, 8'h11);
        chk8("ban_fall_we", 0, 8'(count_we()), 8'd0);

        // JMP F at F: PC wraps to 0 in DECODE, then reloads F forever
        fill_hlt();
        mem[0] = 8'h8F; mem[15] = 8'h8F;
        gen(1'b0, 20);
        run_trace();
        chk8("jmp_wrap_pc", 4, {4'b0, obs_pc[4]}, 8'h00);
        chk8("jmp_fetch5", 5, {3'b0, obs_rd[5], obs_addr[5]}, 8'h1F);
        chk8("jmp_fetch7", 7, {3'b0, obs_rd[7], obs_addr[7]}, 8'h1F);

        // STA 3
        fill_hlt();
        mem[0] = 8'h63;
        gen(1'b0, 100);
        run_trace();
        chk8("sta_alu3", 3, {1'b0, obs_alu[3]}, 8'h06);
        chk8("sta_wr5", 5, {3'b0, obs_wr[5], obs_addr[5]}, 8'h13);
        chk8("sta_we", 0, 8'(count_we()), 8'd0);

        // Random programs with random waits, branch conditions and stray start/ready pulses
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            gen(1'b1, 1500);
            run_trace();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
